// File: rtl/dump_pkg.sv
// Shared types and constants for the end-of-program memory dumper.
package dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    READ,
    WAIT,
    SEND,
    DONE
  } state_t;

  localparam logic [31:0] TRAP_DEFAULT = 32'h44000300;
  localparam logic [31:0] WORD_BYTES   = 32'd4;

endpackage

// File: rtl/trap_mem_dumper.sv
// Halts the core on the halt trap and streams data memory [DUMP_BASE, DUMP_END) as {addr, data} beats.
// Optional feature: define DUMP_CHECKSUM_EN to append a checksum beat at address DUMP_END.
module trap_mem_dumper
  import dump_pkg::*;
#(
  parameter logic [31:0] DUMP_BASE    = 32'h2000,
  parameter logic [31:0] DUMP_END     = 32'h2100,
  parameter logic [31:0] TRAP_WORD    = TRAP_DEFAULT,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] wb_instr,
  input  logic        wb_valid,
  output logic        halt,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_addr,
  output logic [31:0] dump_data,
  output logic        dump_last,
  output logic        done
);

  if (DUMP_END <= DUMP_BASE || DUMP_BASE[1:0] != 2'b00 || DUMP_END[1:0] != 2'b00 ||
      DRAIN_CYCLES < 1 || DRAIN_CYCLES > 256) begin : g_param_check
    $error("trap_mem_dumper: DUMP_BASE/DUMP_END must be word aligned with END > BASE, DRAIN_CYCLES in 1..256");
  end

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  drain_cnt;
  logic        final_beat;

`ifdef DUMP_CHECKSUM_EN
  logic [31:0] csum;
  logic        data_last;

  // The checksum beat is the one that carries last; the final data beat hands over to it.
  assign data_last  = (dump_addr + WORD_BYTES == DUMP_END);
  assign final_beat = (dump_addr == DUMP_END);
`else
  assign final_beat = (dump_addr + WORD_BYTES == DUMP_END);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wb_valid && wb_instr == TRAP_WORD) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = READ;
      READ:    state_nxt = WAIT;
      WAIT:    state_nxt = SEND;
      SEND: begin
        if (dump_ready) begin
          if (final_beat) state_nxt = DONE;
`ifdef DUMP_CHECKSUM_EN
          else if (data_last) state_nxt = SEND;
`endif
          else state_nxt = READ;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    halt       = (state != IDLE);
    mem_rd_en  = (state == READ);
    dump_valid = (state == SEND);
    dump_last  = (state == SEND) && final_beat;
    done       = (state == DONE);
  end

  // Address/data path; the beat registers only move in WAIT and on a SEND handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drain_cnt <= '0;
      mem_addr  <= DUMP_BASE;
      dump_addr <= DUMP_BASE;
      dump_data <= '0;
    end else begin
      drain_cnt <= (state == DRAIN) ? drain_cnt + 8'd1 : 8'd0;
      case (state)
        WAIT: begin
          dump_addr <= mem_addr;
          dump_data <= mem_rdata;
        end
        SEND: begin
          if (dump_ready) begin
            mem_addr <= mem_addr + WORD_BYTES;
`ifdef DUMP_CHECKSUM_EN
            if (data_last) begin
              dump_addr <= DUMP_END;
              dump_data <= csum;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)             csum <= '0;
    else if (state == WAIT) csum <= csum + mem_rdata;
  end
`endif

endmodule

// File: tb/tb_trap_mem_dumper.sv
// Directed bench for trap_mem_dumper: scoreboard of expected beats, immediate-assertion checks.
// Builds with or without DUMP_CHECKSUM_EN; the expected beat stream follows the macro.
module tb_trap_mem_dumper;

  localparam logic [31:0] TRAP  = 32'h44000300;
  localparam logic [31:0] BASE  = 32'h2000;
  localparam logic [31:0] ENDA  = 32'h2100;
  localparam int          DRAIN = 4;
  localparam int          NDATA = 64;
`ifdef DUMP_CHECKSUM_EN
  localparam int          NBEATS = NDATA + 1;
`else
  localparam int          NBEATS = NDATA;
`endif
  localparam int          STALL_LEN = 10;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] wb_instr;
  logic        wb_valid;
  logic        halt;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_addr;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        done;

  logic [31:0] mem [NDATA];
  int          rd_count = 0;
  int          bad_rd   = 0;
  beat_t       sb[$];
  int          errors   = 0;
  int          checks   = 0;
  int          base_rd  = 0;

  trap_mem_dumper #(
    .DUMP_BASE   (BASE),
    .DUMP_END    (ENDA),
    .TRAP_WORD   (TRAP),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wb_instr  (wb_instr),
    .wb_valid  (wb_valid),
    .halt      (halt),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_last (dump_last),
    .done      (done)
  );

  always #5 clock = ~clock;

  // Synchronous-read data memory: word one cycle after the strobe, garbage otherwise.
  always @(posedge clock) begin
    if (mem_rd_en) begin
      rd_count <= rd_count + 1;
      if (mem_addr[1:0] != 2'b00 || mem_addr < BASE || mem_addr >= ENDA || !halt)
        bad_rd <= bad_rd + 1;
      mem_rdata <= mem[mem_addr[7:2]];
    end else begin
      mem_rdata <= 32'hDEADBEEF;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_halt"},       32'(halt),       32'd0);
    check({pfx, "_mem_rd_en"},  32'(mem_rd_en),  32'd0);
    check({pfx, "_dump_valid"}, 32'(dump_valid), 32'd0);
    check({pfx, "_dump_last"},  32'(dump_last),  32'd0);
    check({pfx, "_done"},       32'(done),       32'd0);
    check({pfx, "_mem_addr"},   mem_addr,        BASE);
    check({pfx, "_dump_addr"},  dump_addr,       BASE);
    check({pfx, "_dump_data"},  dump_data,       32'd0);
  endtask

  // Fill memory with word i = i + offset and push the beats the dump should produce.
  task automatic load_expected(input int offset);
    logic [31:0] sum;
    logic [31:0] w;
    sum = '0;
    sb.delete();
    for (int i = 0; i < NDATA; i++) begin
      w      = 32'(i + offset);
      mem[i] = w;
      sum    = sum + w;
`ifdef DUMP_CHECKSUM_EN
      sb.push_back('{addr: BASE + 32'(4 * i), data: w, last: 1'b0});
`else
      sb.push_back('{addr: BASE + 32'(4 * i), data: w, last: (i == NDATA - 1)});
`endif
    end
`ifdef DUMP_CHECKSUM_EN
    sb.push_back('{addr: ENDA, data: sum, last: 1'b1});
`endif
  endtask

  task automatic present_trap();
    wb_instr = TRAP;
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    check("halt_next_cycle", 32'(halt), 32'd1);
  endtask

  // Consume beats against the scoreboard; optionally stall one beat or reset during one.
  task automatic collect(input int n, input int stall_beat, input int abort_beat);
    int    beat;
    int    stalled;
    int    cyc;
    int    last_acc;
    beat_t e;
    beat     = 0;
    stalled  = 0;
    cyc      = 0;
    last_acc = 0;
    while (beat < n && cyc < 3000) begin
      if (dump_valid) begin
        if (beat == abort_beat) begin
          dump_ready = 1'b0;
          #2 reset = 1'b0;
          #1 check_reset_outputs("abort");
          dump_ready = 1'b1;
          return;
        end
        dump_ready = !(beat == stall_beat && stalled < STALL_LEN);
        if (!dump_ready) begin
          stalled++;
          check("stall_addr",  dump_addr,       sb[0].addr);
          check("stall_data",  dump_data,       sb[0].data);
          check("stall_last",  32'(dump_last),  32'(sb[0].last));
          check("stall_reads", 32'(rd_count),   32'(base_rd + beat + 1));
        end else begin
          e = sb.pop_front();
          check($sformatf("beat%0d_addr", beat), dump_addr,      e.addr);
          check($sformatf("beat%0d_data", beat), dump_data,      e.data);
          check($sformatf("beat%0d_last", beat), 32'(dump_last), 32'(e.last));
          if (beat == 1) check("beat_gap", 32'(cyc - last_acc), 32'd3);
          last_acc = cyc;
          beat++;
        end
      end
      tick();
      cyc++;
    end
    dump_ready = 1'b1;
    if (beat < n) check("collect_timeout_beats", 32'(beat), 32'(n));
  endtask

  initial begin
    int n;
    reset      = 1'b0;
    wb_instr   = '0;
    wb_valid   = 1'b0;
    dump_ready = 1'b1;
    for (int i = 0; i < NDATA; i++) mem[i] = '0;
    repeat (2) tick();
    check_reset_outputs("por");
    reset = 1'b1;
    tick();

    // Trap without wb_valid, and a near-miss word with wb_valid, must both be ignored.
    wb_instr = TRAP;
    wb_valid = 1'b0;
    tick();
    wb_instr = 32'h44000301;
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    wb_instr = '0;
    repeat (8) tick();
    check("invalid_trap_halt",  32'(halt),     32'd0);
    check("invalid_trap_reads", 32'(rd_count), 32'd0);

    // Full dump, index pattern, second trap in DRAIN, 10-cycle stall on beat 5.
    base_rd = rd_count;
    load_expected(0);
    present_trap();
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    n = 1;
    while (!mem_rd_en && n < 20) begin
      tick();
      n++;
    end
    check("drain_length", 32'(n), 32'(DRAIN));
    collect(NBEATS, 5, -1);
    check("done_after_dump", 32'(done),       32'd1);
    check("halt_after_dump", 32'(halt),       32'd1);
    check("valid_after_dump", 32'(dump_valid), 32'd0);

    // Trap while DONE: nothing new happens.
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dump_valid) n++;
    end
    check("done_extra_beats", 32'(n),        32'd0);
    check("done_total_reads", 32'(rd_count), 32'(base_rd + NDATA));
    check("done_sticky",      32'(done),     32'd1);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    // Reset pulled during SEND of beat 20.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    base_rd = rd_count;
    load_expected(0);
    present_trap();
    collect(NBEATS, -1, 20);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("post_abort_halt",  32'(halt),       32'd0);
    check("post_abort_valid", 32'(dump_valid), 32'd0);
    repeat (10) tick();
    check("post_abort_reads", 32'(rd_count),   32'(base_rd + 21));
    check("post_abort_idle",  32'(halt),       32'd0);

`ifdef DUMP_CHECKSUM_EN
    // Words 1..64: checksum beat carries 0x820 at DUMP_END.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    base_rd = rd_count;
    load_expected(1);
    present_trap();
    collect(NBEATS, -1, -1);
    check("csum_done", 32'(done), 32'd1);
`endif

    check("read_port_misuse", 32'(bad_rd), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
